fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencing controller for the instruction-fetch unit.
- Arbitrates PC redirect sources (trap, EX-stage branch/jalr, ID-stage jal) and load-use stall into the ifu controls: stall_pc, pc_update_control, pc_update_val.
- Runs the instruction-memory req/gnt/rvalid handshake and tracks outstanding fetches.
- Squashes wrong-path responses after a redirect.
- Sits between the ifu, imem port and the hazard/branch logic of the 5-stage core.

Parameters:
XLEN, 32, address/PC width
MAX_OUTSTANDING, 2, max in-flight imem requests (1..7)
RESET_VECTOR, 32'h0000_0000, PC loaded into ifu at boot

Ports:
i_clk  input  1  core clock
i_rst  input  1  reset, asynchronous, active-high
trap_req  input  1  trap/exception redirect request
trap_target  input  XLEN  trap handler address
br_req  input  1  taken branch/jalr resolved in EX
br_target  input  XLEN  branch/jalr target
jal_req  input  1  jal decoded in ID
jal_target  input  XLEN  jal target
hazard_stall  input  1  load-use stall from hazard unit
imem_req  output  1  fetch request for current ifu pc
imem_gnt  input  1  imem accepts request this cycle
imem_rvalid  input  1  imem returns an instruction
stall_pc  output  1  hold ifu pc
pc_update_control  output  1  load pc_update_val into ifu pc
pc_update_val  output  XLEN  redirect target
flush_if  output  1  kill IF/ID register contents
flush_id  output  1  kill ID/EX register contents
fetch_valid  output  1  imem response is a valid, non-squashed instruction

Behaviour:
- Clock/reset: one clock, i_clk. i_rst is asynchronous, active-high.
- State is registered; outputs are combinational from state and inputs.
- While i_rst is high, outputs are forced to: imem_req=0, stall_pc=1, pc_update_control=0, pc_update_val=0, flush_if=0, flush_id=0, fetch_valid=0.
- Reset values: state=BOOT, outstanding=0, squash_cnt=0.
- FSM states: BOOT, RUN, SQUASH.
- BOOT lasts 1 cycle after reset release:
  - pc_update_control=1, pc_update_val=RESET_VECTOR, stall_pc=0, imem_req=0.
  - Then goes to RUN.
- Redirect priority: trap > br > jal. Exactly one redirect is accepted per cycle; losing sources are ignored (not queued).
- Redirect cycle (any accepted req, state RUN or SQUASH):
  - pc_update_control=1, pc_update_val=winner target, stall_pc=0 (overrides hazard_stall), imem_req=0, fetch_valid=0.
  - trap or br: flush_if=1, flush_id=1.
  - jal: flush_if=1, flush_id=0.
  - squash_cnt_next = outstanding - imem_rvalid.
  - Next state = SQUASH if squash_cnt_next > 0, else RUN.
- Non-redirect cycle:
  - imem_req = !hazard_stall && outstanding < MAX_OUTSTANDING && state != BOOT.
  - stall_pc = !(imem_req && imem_gnt). The PC advances by 4 in the ifu only on an accepted fetch.
  - pc_update_control=0.
- Outstanding counter (width clog2(MAX_OUTSTANDING+1)): next = outstanding + (imem_req && imem_gnt) - imem_rvalid.
- Response handling:
  - fetch_valid = imem_rvalid && squash_cnt==0 && no redirect this cycle.
  - In SQUASH, each rvalid decrements squash_cnt and is dropped.
  - Go to RUN when squash_cnt reaches 0.
  - New fetches are allowed during SQUASH; squash_cnt counts only pre-redirect requests.
- A redirect arriving in SQUASH reloads squash_cnt per the redirect rule.
- Protocol-error cases:
  - imem_rvalid with outstanding==0: ignored, counters saturate at 0, fetch_valid=0.
  - imem_gnt without imem_req: ignored.
- Asserting i_rst mid-fetch: all counters clear and in-flight responses are forgotten. Responses arriving after reset release with outstanding==0 are ignored per the rule above.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with stall_pc=1 in RUN/SQUASH) and perf_redirects[31:0] (accepted redirects).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, SQUASH} fetch_state_t
  - typedef enum {REDIR_NONE, REDIR_TRAP, REDIR_BR, REDIR_JAL} redir_src_t
  - XLEN default and RESET_VECTOR default
- One sub-module, redirect_arb: combinational priority select producing redir_valid, redir_src and redir_target.

Test Plan:
- Reset release: next cycle pc_update_control=1, pc_update_val=0; following cycle imem_req=1, stall_pc=0 with gnt=1.
- gnt=1 every cycle, rvalid 1 cycle later: outstanding stays ≤1, fetch_valid=1 each response, stall_pc=0.
- MAX_OUTSTANDING=2, gnt=1, rvalid held low 3 cycles: third cycle imem_req=0, stall_pc=1.
- br_req with target 0x100 and 2 outstanding:
  - that cycle pc_update_val=0x100, flush_if=flush_id=1.
  - next two rvalids give fetch_valid=0; the third rvalid gives fetch_valid=1.
- trap_req (0x80), br_req (0x100) and jal_req (0x200) in the same cycle: pc_update_val=0x80, flush_id=1.
- hazard_stall=1 with jal_req=1: stall_pc=0, pc_update_control=1, flush_if=1, flush_id=0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and defaults for the instruction-fetch
//               sequencing controller. Holds the controller state encoding,
//               the redirect-source encoding and the default XLEN and reset
//               vector.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  typedef enum {
    REDIR_NONE,
    REDIR_TRAP,
    REDIR_BR,
    REDIR_JAL
  } redir_src_t;

endpackage
`default_nettype wire

// File: rtl/redirect_arb.sv
`default_nettype none
// ============================================================================
// Module      : redirect_arb
// Description : Fixed-priority selector for PC redirect sources.
//               Priority is trap > branch/jalr > jal; only the winner is
//               reported, losers are dropped.
// Ports       : trap_req/trap_target  - trap redirect
//               br_req/br_target      - EX-stage branch/jalr redirect
//               jal_req/jal_target    - ID-stage jal redirect
//               redir_valid           - some source is requesting
//               redir_src             - winning source
//               redir_target          - winning target address
// Revision    : 1.0 - initial release
// ============================================================================
module redirect_arb
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_req,
  input  logic [XLEN-1:0] jal_target,
  output logic            redir_valid,
  output redir_src_t      redir_src,
  output logic [XLEN-1:0] redir_target
);

  always_comb begin
    redir_valid  = 1'b0;
    redir_src    = REDIR_NONE;
    redir_target = '0;
    if (trap_req) begin
      redir_valid  = 1'b1;
      redir_src    = REDIR_TRAP;
      redir_target = trap_target;
    end else if (br_req) begin
      redir_valid  = 1'b1;
      redir_src    = REDIR_BR;
      redir_target = br_target;
    end else if (jal_req) begin
      redir_valid  = 1'b1;
      redir_src    = REDIR_JAL;
      redir_target = jal_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencing controller. Arbitrates PC
//               redirects and load-use stalls into the ifu PC controls, runs
//               the imem req/gnt/rvalid handshake, tracks in-flight fetches
//               and squashes wrong-path responses after a redirect.
// Build macro : FETCH_PERF_EN - adds perf_stall_cycles / perf_redirects.
// Ports       : i_clk, i_rst (async, active-high)
//               trap_/br_/jal_ req+target - redirect sources
//               hazard_stall              - load-use stall
//               imem_req/imem_gnt/imem_rvalid - imem handshake
//               stall_pc, pc_update_control, pc_update_val - ifu controls
//               flush_if, flush_id        - pipeline register kills
//               fetch_valid               - response is on the correct path
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEFAULT,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR    = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_req,
  input  logic [XLEN-1:0] jal_target,
  input  logic            hazard_stall,
  output logic            imem_req,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  output logic            stall_pc,
  output logic            pc_update_control,
  output logic [XLEN-1:0] pc_update_val,
  output logic            flush_if,
  output logic            flush_id,
  output logic            fetch_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_redirects
`endif
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  fetch_state_t     r_state, w_state_next;
  logic [CNT_W-1:0] r_outstanding, w_outstanding_next;
  logic [CNT_W-1:0] r_squash_cnt, w_squash_cnt_next;

  logic             w_redir_valid;
  redir_src_t       w_redir_src;
  logic [XLEN-1:0]  w_redir_target;
  logic             w_redirect;
  logic             w_rsp;
  logic             w_accept;

  redirect_arb #(
    .XLEN (XLEN)
  ) u_redirect_arb (
    .trap_req     (trap_req),
    .trap_target  (trap_target),
    .br_req       (br_req),
    .br_target    (br_target),
    .jal_req      (jal_req),
    .jal_target   (jal_target),
    .redir_valid  (w_redir_valid),
    .redir_src    (w_redir_src),
    .redir_target (w_redir_target)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= BOOT;
      r_outstanding <= '0;
      r_squash_cnt  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      r_squash_cnt  <= w_squash_cnt_next;
    end
  end

  always_comb begin
    imem_req           = 1'b0;
    stall_pc           = 1'b1;
    pc_update_control  = 1'b0;
    pc_update_val      = '0;
    flush_if           = 1'b0;
    flush_id           = 1'b0;
    fetch_valid        = 1'b0;
    w_redirect         = 1'b0;
    w_accept           = 1'b0;
    w_state_next       = r_state;
    w_outstanding_next = r_outstanding;
    w_squash_cnt_next  = r_squash_cnt;
    // A response with nothing in flight is a protocol error and is dropped,
    // which also keeps the counters from wrapping below zero.
    w_rsp = imem_rvalid && (r_outstanding != '0);

    // Outputs are forced while reset is held even though BOOT is the reset
    // state, because BOOT itself drives a PC load.
    if (!i_rst) begin
      if (r_state == BOOT) begin
        pc_update_control = 1'b1;
        pc_update_val     = RESET_VECTOR;
        stall_pc          = 1'b0;
        w_state_next      = RUN;
      end else if (w_redir_valid) begin
        w_redirect         = 1'b1;
        pc_update_control  = 1'b1;
        pc_update_val      = w_redir_target;
        stall_pc           = 1'b0;
        flush_if           = 1'b1;
        flush_id           = (w_redir_src != REDIR_JAL);
        // Everything still in flight belongs to the old path.
        w_outstanding_next = r_outstanding - CNT_W'(w_rsp);
        w_squash_cnt_next  = w_outstanding_next;
        w_state_next       = (w_squash_cnt_next != '0) ? SQUASH : RUN;
      end else begin
        imem_req           = !hazard_stall && (r_outstanding < MAX_CNT);
        w_accept           = imem_req && imem_gnt;
        stall_pc           = !w_accept;
        w_outstanding_next = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);
        fetch_valid        = w_rsp && (r_squash_cnt == '0);
        if (w_rsp && (r_squash_cnt != '0)) begin
          w_squash_cnt_next = r_squash_cnt - 1'b1;
        end
        w_state_next = (w_squash_cnt_next != '0) ? SQUASH : RUN;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_stall_cycles;
  logic [31:0] r_perf_redirects;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_stall_cycles <= '0;
      r_perf_redirects    <= '0;
    end else begin
      if (stall_pc && (r_state != BOOT)) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
      if (w_redirect) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall_cycles;
  assign perf_redirects    = r_perf_redirects;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl (XLEN=32,
//               MAX_OUTSTANDING=2, RESET_VECTOR=0). Inputs change 1ns after
//               the rising edge; outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        trap_req, br_req, jal_req, hazard_stall;
  logic [31:0] trap_target, br_target, jal_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic        stall_pc, pc_update_control, flush_if, flush_id, fetch_valid;
  logic [31:0] pc_update_val;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(
    .XLEN            (32),
    .MAX_OUTSTANDING (2),
    .RESET_VECTOR    (32'h0000_0000)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .trap_req          (trap_req),
    .trap_target       (trap_target),
    .br_req            (br_req),
    .br_target         (br_target),
    .jal_req           (jal_req),
    .jal_target        (jal_target),
    .hazard_stall      (hazard_stall),
    .imem_req          (imem_req),
    .imem_gnt          (imem_gnt),
    .imem_rvalid       (imem_rvalid),
    .stall_pc          (stall_pc),
    .pc_update_control (pc_update_control),
    .pc_update_val     (pc_update_val),
    .flush_if          (flush_if),
    .flush_id          (flush_id),
    .fetch_valid       (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs right after the rising edge.
  task automatic drive(input logic gnt, input logic rvalid, input logic hz,
                       input logic t, input logic b, input logic j);
    imem_gnt     = gnt;
    imem_rvalid  = rvalid;
    hazard_stall = hz;
    trap_req     = t;
    br_req       = b;
    jal_req      = j;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    trap_target = 32'h80;
    br_target   = 32'h100;
    jal_target  = 32'h200;
    drive(0, 0, 0, 0, 0, 0);

    // ---- reset state ----
    sample();
    check("rst_imem_req", imem_req, 0);
    check("rst_stall_pc", stall_pc, 1);
    check("rst_pc_upd", pc_update_control, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // ---- BOOT cycle ----
    sample();
    check("boot_pc_upd", pc_update_control, 1);
    check("boot_pc_val", pc_update_val, 32'h0);
    check("boot_imem_req", imem_req, 0);
    check("boot_stall_pc", stall_pc, 0);
    next_cycle();

    // ---- first fetch, gnt=1 ----
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("run_imem_req", imem_req, 1);
    check("run_stall_pc", stall_pc, 0);
    check("run_pc_upd", pc_update_control, 0);
    next_cycle();

    // ---- streaming: gnt every cycle, rvalid one cycle later ----
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      sample();
      check("stream_fetch_valid", fetch_valid, 1);
      check("stream_imem_req", imem_req, 1);
      check("stream_stall_pc", stall_pc, 0);
      next_cycle();
    end

    // ---- drain the single outstanding fetch (no grant) ----
    drive(0, 1, 0, 0, 0, 0);
    sample();
    check("drain_fetch_valid", fetch_valid, 1);
    check("drain_stall_pc", stall_pc, 1);
    next_cycle();

    // ---- fill to MAX_OUTSTANDING with rvalid held low ----
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("fill1_imem_req", imem_req, 1);
    next_cycle();
    sample();
    check("fill2_imem_req", imem_req, 1);
    next_cycle();
    sample();
    check("full_imem_req", imem_req, 0);
    check("full_stall_pc", stall_pc, 1);
    next_cycle();

    // ---- branch redirect with 2 outstanding ----
    drive(0, 0, 0, 0, 1, 0);
    sample();
    check("br_pc_upd", pc_update_control, 1);
    check("br_pc_val", pc_update_val, 32'h100);
    check("br_flush_if", flush_if, 1);
    check("br_flush_id", flush_id, 1);
    check("br_stall_pc", stall_pc, 0);
    check("br_imem_req", imem_req, 0);
    next_cycle();
    // first stale response: still full, so no new request
    drive(1, 1, 0, 0, 0, 0);
    sample();
    check("sq1_fetch_valid", fetch_valid, 0);
    check("sq1_imem_req", imem_req, 0);
    next_cycle();
    // second stale response: one slot free, new fetch allowed during squash
    drive(1, 1, 0, 0, 0, 0);
    sample();
    check("sq2_fetch_valid", fetch_valid, 0);
    check("sq2_imem_req", imem_req, 1);
    next_cycle();
    // third response belongs to the new path
    drive(0, 1, 0, 0, 0, 0);
    sample();
    check("sq3_fetch_valid", fetch_valid, 1);
    next_cycle();

    // ---- simultaneous trap/br/jal: trap wins ----
    drive(0, 0, 0, 1, 1, 1);
    sample();
    check("prio_pc_val", pc_update_val, 32'h80);
    check("prio_flush_id", flush_id, 1);
    check("prio_flush_if", flush_if, 1);
    next_cycle();

    // ---- br beats jal ----
    drive(0, 0, 0, 0, 1, 1);
    sample();
    check("brjal_pc_val", pc_update_val, 32'h100);
    check("brjal_flush_id", flush_id, 1);
    next_cycle();

    // ---- jal during hazard stall ----
    drive(0, 0, 1, 0, 0, 1);
    sample();
    check("jalhz_stall_pc", stall_pc, 0);
    check("jalhz_pc_upd", pc_update_control, 1);
    check("jalhz_pc_val", pc_update_val, 32'h200);
    check("jalhz_flush_if", flush_if, 1);
    check("jalhz_flush_id", flush_id, 0);
    next_cycle();

    // ---- plain hazard stall ----
    drive(1, 0, 1, 0, 0, 0);
    sample();
    check("hz_imem_req", imem_req, 0);
    check("hz_stall_pc", stall_pc, 1);
    check("hz_pc_upd", pc_update_control, 0);
    next_cycle();

    // ---- spurious rvalid with nothing outstanding ----
    drive(0, 1, 0, 0, 0, 0);
    sample();
    check("spur_fetch_valid", fetch_valid, 0);
    next_cycle();
    // counter must still be 0: two accepted fetches fit, third is blocked
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("spur_req1", imem_req, 1);
    next_cycle();
    sample();
    check("spur_req2", imem_req, 1);
    next_cycle();
    sample();
    check("spur_req3", imem_req, 0);

    // ---- reset asserted mid-fetch (asynchronously) ----
    #1;
    rst = 1'b1;
    #1;
    check("midrst_imem_req", imem_req, 0);
    check("midrst_stall_pc", stall_pc, 1);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    sample();
    check("reboot_pc_upd", pc_update_control, 1);
    next_cycle();
    // stale response after reset: forgotten
    drive(0, 1, 0, 0, 0, 0);
    sample();
    check("postrst_fetch_valid", fetch_valid, 0);
    check("postrst_imem_req", imem_req, 1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
